// File: rtl/io_map_pkg.sv
// Shared IO address map and read-select decode for the input conditioner
// and the rest of the core's IO decode.
package io_map_pkg;

    localparam logic [31:0] IO_ADDR_SW        = 32'd1;
    localparam logic [31:0] IO_ADDR_BTN       = 32'd2;
    localparam logic [31:0] IO_ADDR_BTN_PRESS = 32'd3;
    localparam int unsigned IO_LED_WR_BIT     = 2;

    typedef enum logic [1:0] {
        IO_SEL_NONE,
        IO_SEL_SW,
        IO_SEL_BTN,
        IO_SEL_PRESS
    } io_sel_e;

    function automatic io_sel_e io_decode(input logic [31:0] addr);
        case (addr)
            IO_ADDR_SW:        return IO_SEL_SW;
            IO_ADDR_BTN:       return IO_SEL_BTN;
            IO_ADDR_BTN_PRESS: return IO_SEL_PRESS;
            default:           return IO_SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_input_conditioner_if.sv
// Core IO read bus: the core drives address/strobe, the peripheral returns data.
interface io_bus_if;

    logic [31:0] io_address;
    logic        io_read_en;
    logic [31:0] io_read_value;

    modport master (output io_address, output io_read_en, input  io_read_value);
    modport slave  (input  io_address, input  io_read_en, output io_read_value);

endinterface

// File: rtl/debounce_bit.sv
// One raw input bit: 2-flop synchronizer, then a saturating stability counter
// that flips the clean level after STABLE_SAMPLES consecutive differing ticks.
module debounce_bit #(
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic tick,
    output logic dout
);

    localparam int unsigned CW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;

    always_comb begin
        sync_d  = {sync_q[0], din};
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (tick) begin
            if (sync_q[1] != clean_q) begin
                // The counter never holds STABLE_SAMPLES: the last step flips instead.
                if (cnt_q == CNT_LAST) begin
                    clean_d = ~clean_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign dout = clean_q;

endmodule

// File: rtl/io_input_conditioner.sv
// Debounces the board switches/buttons, latches button press events and
// exposes both through a registered read port on the core IO bus.
module io_input_conditioner
    import io_map_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV     = 100000,
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic        CLK100MHZ,
    input  logic        CPU_RESETN,
    input  logic [15:0] SW,
    input  logic [4:0]  BTN,
    input  logic [31:0] io_address,
    input  logic        io_read_en,
    output logic [31:0] io_read_value,
    output logic [15:0] sw_clean,
    output logic [4:0]  btn_clean,
    output logic [4:0]  btn_press
);

    localparam int unsigned PW = $clog2(SAMPLE_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SAMPLE_DIV - 1);

    logic [1:0]    rst_sync_q, rst_sync_d;
    logic          rst_n;
    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    logic [20:0]   raw_in;
    logic [20:0]   clean;
    logic [4:0]    btn_prev_q, btn_prev_d;
    logic [4:0]    press_q, press_d;
    logic [31:0]   read_value_q, read_value_d;
    io_sel_e       sel;

    // Assert follows CPU_RESETN immediately; release waits two clock edges.
    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) rst_sync_q <= '0;
        else             rst_sync_q <= rst_sync_d;
    end

    assign rst_n  = rst_sync_q[1];
    assign tick   = (pre_q == PRE_LAST);
    assign raw_in = {BTN, SW};

    for (genvar i = 0; i < 21; i++) begin : g_db
        debounce_bit #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_db (
            .clk  (CLK100MHZ),
            .rst_n(rst_n),
            .din  (raw_in[i]),
            .tick (tick),
            .dout (clean[i])
        );
    end

    assign sw_clean  = clean[15:0];
    assign btn_clean = clean[20:16];

    always_comb begin
        pre_d        = tick ? '0 : pre_q + 1'b1;
        btn_prev_d   = btn_clean;
        sel          = io_decode(io_address);
        read_value_d = read_value_q;
        press_d      = press_q | (btn_clean & ~btn_prev_q);
        if (io_read_en) begin
            case (sel)
                IO_SEL_SW:    read_value_d = {16'b0, sw_clean};
                IO_SEL_BTN:   read_value_d = {27'b0, btn_clean};
                IO_SEL_PRESS: read_value_d = {27'b0, press_q};
                default:      read_value_d = '0;
            endcase
            // Clear only what is returned; a same-cycle new edge is OR'd back in.
            if (sel == IO_SEL_PRESS)
                press_d = (press_q & ~press_q) | (btn_clean & ~btn_prev_q);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            pre_q        <= '0;
            btn_prev_q   <= '0;
            press_q      <= '0;
            read_value_q <= '0;
        end else begin
            pre_q        <= pre_d;
            btn_prev_q   <= btn_prev_d;
            press_q      <= press_d;
            read_value_q <= read_value_d;
        end
    end

    assign io_read_value = read_value_q;
    assign btn_press     = press_q;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomized and directed bench for io_input_conditioner against a
// tick-level behavioural model of debounce, press latching and read decode.
module tb_io_input_conditioner;

    localparam int unsigned SD = 4;
    localparam int unsigned SS = 3;

    logic        clk = 1'b0;
    logic        CPU_RESETN;
    logic [15:0] SW;
    logic [4:0]  BTN;
    logic [15:0] sw_clean;
    logic [4:0]  btn_clean;
    logic [4:0]  btn_press;

    io_bus_if bus ();

    always #5 clk = ~clk;

    io_input_conditioner #(.SAMPLE_DIV(SD), .STABLE_SAMPLES(SS)) dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (CPU_RESETN),
        .SW           (SW),
        .BTN          (BTN),
        .io_address   (bus.io_address),
        .io_read_en   (bus.io_read_en),
        .io_read_value(bus.io_read_value),
        .sw_clean     (sw_clean),
        .btn_clean    (btn_clean),
        .btn_press    (btn_press)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    // Model: raw samples reach the debouncer two active edges late; on every
    // SD-th active edge each bit counts disagreements and flips after SS of them.
    logic [20:0] m_h1 = '0, m_h2 = '0, m_clean = '0, m_prev = '0;
    logic [4:0]  m_press = '0, m_new = '0;
    logic [31:0] m_rv = '0;
    int          m_streak [21];
    int          m_phase = 0, m_rs = 0;
    bit          m_tick;

    always @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            m_h1 = '0; m_h2 = '0; m_clean = '0; m_prev = '0;
            m_press = '0; m_rv = '0; m_phase = 0; m_rs = 0;
            foreach (m_streak[i]) m_streak[i] = 0;
        end else if (m_rs < 2) begin
            m_rs++;
        end else begin
            m_tick  = (m_phase == SD - 1);
            m_phase = (m_phase + 1) % SD;
            m_new   = m_clean[20:16] & ~m_prev[20:16];
            if (bus.io_read_en) begin
                case (bus.io_address)
                    32'd1:   m_rv = {16'h0, m_clean[15:0]};
                    32'd2:   m_rv = {27'h0, m_clean[20:16]};
                    32'd3:   m_rv = {27'h0, m_press};
                    default: m_rv = 32'h0;
                endcase
            end
            if (bus.io_read_en && bus.io_address == 32'd3) m_press = m_new;
            else                                           m_press = m_press | m_new;
            m_prev = m_clean;
            if (m_tick) begin
                for (int i = 0; i < 21; i++) begin
                    if (m_h2[i] != m_clean[i]) begin
                        m_streak[i]++;
                        if (m_streak[i] == SS) begin
                            m_clean[i]  = ~m_clean[i];
                            m_streak[i] = 0;
                        end
                    end else begin
                        m_streak[i] = 0;
                    end
                end
            end
            m_h2 = m_h1;
            m_h1 = {BTN, SW};
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("mon_sw_clean",  {16'h0, sw_clean},  {16'h0, m_clean[15:0]});
            check_eq("mon_btn_clean", {27'h0, btn_clean}, {27'h0, m_clean[20:16]});
            check_eq("mon_btn_press", {27'h0, btn_press}, {27'h0, m_press});
            check_eq("mon_read_value", bus.io_read_value, m_rv);
        end
    end

    task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.io_address = a;
        bus.io_read_en = 1'b1;
        @(posedge clk);
        #1 v = bus.io_read_value;
        @(negedge clk);
        bus.io_read_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_sw"},   {16'h0, sw_clean},  32'h0);
        check_eq({tag, "_btn"},  {27'h0, btn_clean}, 32'h0);
        check_eq({tag, "_prs"},  {27'h0, btn_press}, 32'h0);
        check_eq({tag, "_rv"},   bus.io_read_value,  32'h0);
    endtask

    logic [31:0] rv;
    int          n;
    bit          seen;
    logic [31:0] addr_tab [6];

    initial begin
        CPU_RESETN     = 1'b0;
        SW             = 16'hFFFF;
        BTN            = 5'b0;
        bus.io_address = '0;
        bus.io_read_en = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        check_all_zero("reset");

        // Held switches qualify on the third tick after release, not sooner.
        #2 CPU_RESETN = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (sw_clean == 16'hFFFF) break;
        end
        check_eq("rst_qual_window", {31'h0, (n >= 14 && n <= 16)}, 32'h1);

        // Glitch: two ticks of a pressed button must not qualify.
        @(negedge clk);
        BTN[0] = 1'b1;
        repeat (8) @(negedge clk);
        BTN[0] = 1'b0;
        repeat (20) @(negedge clk);
        check_eq("glitch_btn_clean", {27'h0, btn_clean}, 32'h0);
        check_eq("glitch_btn_press", {27'h0, btn_press}, 32'h0);

        // Press latch then clear-on-read.
        BTN[2] = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("press_btn_clean", {27'h0, btn_clean}, 32'h4);
        check_eq("press_btn_press", {27'h0, btn_press}, 32'h4);
        bus_read(32'd3, rv);
        check_eq("press_read1", rv, 32'h4);
        bus_read(32'd3, rv);
        check_eq("press_read2", rv, 32'h0);

        // Read mux decode and hold.
        SW = 16'hA5C3;
        repeat (20) @(negedge clk);
        bus_read(32'd7, rv);
        check_eq("mux_addr7", rv, 32'h0);
        bus_read(32'd1, rv);
        check_eq("mux_addr1", rv, 32'h0000A5C3);
        bus_read(32'd2, rv);
        check_eq("mux_addr2", rv, 32'h4);
        repeat (3) @(negedge clk);
        check_eq("mux_hold", bus.io_read_value, 32'h4);

        // Race: clearing read in the same cycle btn_clean[1] rises.
        BTN[1] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (btn_clean[1]) begin seen = 1'b1; break; end
        end
        check_eq("race_seen", {31'h0, seen}, 32'h1);
        bus.io_address = 32'd3;
        bus.io_read_en = 1'b1;
        @(posedge clk);
        #1;
        check_eq("race_read_bit1", {31'h0, bus.io_read_value[1]}, 32'h0);
        check_eq("race_press_bit1", {31'h0, btn_press[1]}, 32'h1);
        @(negedge clk);
        bus.io_read_en = 1'b0;

        // Reset mid-count discards two ticks of progress on BTN[3].
        BTN[3] = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m_streak[19] == 2) break;
        end
        check_eq("midrst_progress", m_streak[19], 32'd2);
        #2 CPU_RESETN = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("midrst");
        #2 CPU_RESETN = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (btn_clean[3]) break;
        end
        check_eq("midrst_requal_window", {31'h0, (n >= 14 && n <= 16)}, 32'h1);

        // Randomized traffic, checked every cycle by the monitor.
        addr_tab[0] = 32'd0; addr_tab[1] = 32'd1; addr_tab[2] = 32'd2;
        addr_tab[3] = 32'd3; addr_tab[4] = 32'd7; addr_tab[5] = 32'h0001_0003;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if ($urandom_range(15) == 0) SW[$urandom_range(15)] = ~SW[$urandom_range(15)];
            if ($urandom_range(23) == 0) BTN[$urandom_range(4)] = $urandom_range(1) == 1;
            bus.io_read_en = ($urandom_range(2) == 0);
            bus.io_address = addr_tab[$urandom_range(5)];
        end
        @(negedge clk);
        bus.io_read_en = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_input_conditioner.md
IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 100000, clock cycles per debounce sample tick (1 ms at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter STABLE_SAMPLES, default 4, consecutive differing samples required to change a clean bit; legal range >= 1.
REQ-003 SHALL have port CLK100MHZ  in  1  sole clock, rising edge.
REQ-004 SHALL have port CPU_RESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port SW  in  16  raw, asynchronous slide switches.
REQ-006 SHALL have port BTN  in  5  raw, asynchronous push buttons, 1 = pressed.
REQ-007 SHALL have port io_address  in  32  core IO bus address.
REQ-008 SHALL have port io_read_en  in  1  core IO read strobe.
REQ-009 SHALL have port io_read_value  out  32  registered read data to core.
REQ-010 SHALL have port sw_clean  out  16  debounced switch levels.
REQ-011 SHALL have port btn_clean  out  5  debounced button levels.
REQ-012 SHALL have port btn_press  out  5  sticky press-event flags.

Function
REQ-013 Each SW/BTN bit SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Shared prescaler SHALL count 0..SAMPLE_DIV-1, assert a 1-cycle tick at SAMPLE_DIV-1, then wrap to 0.
REQ-015 Per bit, on a tick: synced != clean increments stability counter; synced == clean clears it to 0; no change between ticks.
REQ-016 Clean bit SHALL toggle on the tick where the counter would reach STABLE_SAMPLES; counter clears in the same cycle.
REQ-017 btn_press[i] SHALL set in the cycle after btn_clean[i] rises 0->1; falling edges have no effect.
REQ-018 Read: io_read_en high at cycle N SHALL produce io_read_value at N+1; value holds while io_read_en is low.
REQ-019 Decode, full 32-bit compare: 1 -> {16'b0, sw_clean}; 2 -> {27'b0, btn_clean}; 3 -> {27'b0, btn_press}; any other -> 0.
REQ-020 A read of address 3 SHALL clear exactly the btn_press bits returned.
REQ-021 A press edge in the same cycle as the clearing read SHALL win: bit remains 1, read returns the pre-edge value.
REQ-022 Counter widths SHALL be $clog2 of their range; no overflow or wrap past STABLE_SAMPLES.

Reset
REQ-023 CPU_RESETN low SHALL asynchronously clear synchronizers, prescaler, stability counters, sw_clean, btn_clean, btn_press, and io_read_value to 0.
REQ-024 Reset mid-count SHALL discard partial stability progress; after release, a held input re-qualifies from zero.
REQ-025 Release SHALL be synchronous to CLK100MHZ via a 2-flop reset synchronizer.

Structure
REQ-026 Package io_map_pkg SHALL hold IO_ADDR_SW=1, IO_ADDR_BTN=2, IO_ADDR_BTN_PRESS=3 and the LED write-decode bit index (2), shared with the top-level decode.
REQ-027 Sub-module debounce_bit SHALL contain synchronizer plus stability counter, instantiated 21 times; prescaler, press latches, and read mux stay in the parent.

Verification (SAMPLE_DIV=4, STABLE_SAMPLES=3)
REQ-028 Reset: CPU_RESETN low, SW=16'hFFFF -> all outputs 0; after release sw_clean=16'hFFFF within 2 + 3*4 + 2 cycles, and not before the third tick.
REQ-029 Glitch: BTN[0]=1 for 2 ticks, then 0 -> btn_clean and btn_press stay 5'b00000.
REQ-030 Press/clear: BTN[2] held -> btn_clean=5'b00100, btn_press=5'b00100; read addr 3 -> 0x00000004 next cycle; second read -> 0x00000000.
REQ-031 Mux: SW=16'hA5C3 stable; read addr 1 -> 0x0000A5C3; addr 2 -> btn_clean; addr 7 -> 0x00000000; io_read_en low -> value unchanged.
REQ-032 Race: btn_clean[1] rises in the same cycle as an addr-3 read -> returned bit1=0; btn_press[1]=1 afterwards.
REQ-033 Reset mid-count: BTN[3] held 2 ticks, pulse CPU_RESETN low -> after release, btn_clean[3] rises only after 3 further ticks.
